// File: rtl/coin_vend_ctrl_pkg.sv
// Shared types and constants for the coin vending controller.
//   state_e   : controller FSM states
//   VAL_*     : coin values in quarter-pound units
//   onehot3() : true when exactly one classifier line is asserted
package coin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_JUDGE,
    ST_WAIT_CLR,
    ST_VEND,
    ST_CHANGE
  } state_e;

  localparam int unsigned VAL_POUND   = 4;
  localparam int unsigned VAL_PIASTER = 2;
  localparam int unsigned VAL_NICKEL  = 1;

  function automatic logic onehot3(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

endpackage

// File: rtl/coin_vend_ctrl_if.sv
// Signal bundle between the coin mechanism/customer panel and the controller.
//   slave  : controller side (samples sensor/classifier/Cancel, drives gates,
//            vend/return pulses, Credit and Busy)
//   master : mechanism side (the opposite directions)
interface coin_vend_ctrl_if #(
  parameter int unsigned CREDIT_W = 4
);
  logic                CoinIn;
  logic                Pound;
  logic                Piaster;
  logic                Nickel;
  logic                Cancel;
  logic                Accept;
  logic                Reject;
  logic                Vend;
  logic                RetPound;
  logic                RetPiaster;
  logic                RetNickel;
  logic [CREDIT_W-1:0] Credit;
  logic                Busy;

  modport slave (
    input  CoinIn, Pound, Piaster, Nickel, Cancel,
    output Accept, Reject, Vend, RetPound, RetPiaster, RetNickel, Credit, Busy
  );

  modport master (
    output CoinIn, Pound, Piaster, Nickel, Cancel,
    input  Accept, Reject, Vend, RetPound, RetPiaster, RetNickel, Credit, Busy
  );
endinterface

// File: rtl/coin_vend_ctrl_change_sel.sv
// Change selector: picks the largest coin not exceeding the remaining credit.
//   credit_i : remaining credit (quarter-pound units)
//   coin_o   : one-hot {pound, piaster, nickel}; all zero when credit_i is 0
//   value_o  : value of the selected coin
module coin_change_sel
  import coin_pkg::*;
#(
  parameter int unsigned CREDIT_W = 4
) (
  input  logic [CREDIT_W-1:0] credit_i,
  output logic [2:0]          coin_o,
  output logic [CREDIT_W-1:0] value_o
);

  always_comb begin
    coin_o  = '0;
    value_o = '0;
    if (credit_i >= CREDIT_W'(VAL_POUND)) begin
      coin_o  = 3'b100;
      value_o = CREDIT_W'(VAL_POUND);
    end else if (credit_i >= CREDIT_W'(VAL_PIASTER)) begin
      coin_o  = 3'b010;
      value_o = CREDIT_W'(VAL_PIASTER);
    end else if (credit_i != '0) begin
      coin_o  = 3'b001;
      value_o = CREDIT_W'(VAL_NICKEL);
    end
  end

endmodule

// File: rtl/coin_vend_ctrl.sv
// Coin vending sequencing controller.
//   CLK : system clock, rising edge
//   RST : asynchronous active-low reset
//   bus : coin_vend_ctrl_if slave -- sensor/classifier/Cancel in; gate,
//         vend and change-return pulses, Credit and Busy out (all registered)
// Waits SETTLE cycles of CoinIn, judges the classifier once, gates the coin,
// vends at PRICE and pays change largest-coin-first; Cancel in IDLE refunds.
module coin_vend_ctrl
  import coin_pkg::*;
#(
  parameter int unsigned PRICE      = 6,
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned MAX_CREDIT = 15,
  parameter int unsigned SETTLE     = 2
) (
  input  logic             CLK,
  input  logic             RST,
  coin_vend_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(SETTLE + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                accept_q, accept_d, reject_q, reject_d, vend_q, vend_d;
  logic                rpound_q, rpound_d, rpiast_q, rpiast_d, rnick_q, rnick_d;
  logic                busy_q, busy_d;
  logic [2:0]          cls;
  logic [CREDIT_W:0]   coin_val, sum;
  logic [2:0]          chg_coin;
  logic [CREDIT_W-1:0] chg_val;

  coin_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
    .credit_i (credit_q),
    .coin_o   (chg_coin),
    .value_o  (chg_val)
  );

  assign cls     = {bus.Pound, bus.Piaster, bus.Nickel};
  assign cnt_inc = cnt_q + CNT_W'(1);
  // One bit wider than Credit so the MAX_CREDIT test cannot wrap.
  assign sum     = {1'b0, credit_q} + coin_val;

  always_comb begin
    coin_val = '0;
    if (bus.Pound)        coin_val = (CREDIT_W+1)'(VAL_POUND);
    else if (bus.Piaster) coin_val = (CREDIT_W+1)'(VAL_PIASTER);
    else if (bus.Nickel)  coin_val = (CREDIT_W+1)'(VAL_NICKEL);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    credit_d = credit_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    vend_d   = 1'b0;
    rpound_d = 1'b0;
    rpiast_d = 1'b0;
    rnick_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.CoinIn) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if (bus.Cancel && credit_q != '0) begin
          state_d = ST_CHANGE;
        end
      end
      ST_SETTLE: begin
        if (!bus.CoinIn) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(SETTLE)) state_d = ST_JUDGE;
        end
      end
      ST_JUDGE: begin
        if (onehot3(cls) && sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
          accept_d = 1'b1;
          credit_d = sum[CREDIT_W-1:0];
        end else begin
          reject_d = 1'b1;
        end
        state_d = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (!bus.CoinIn)
          state_d = (credit_q >= CREDIT_W'(PRICE)) ? ST_VEND : ST_IDLE;
      end
      ST_VEND: begin
        vend_d   = 1'b1;
        credit_d = credit_q - CREDIT_W'(PRICE);
        state_d  = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        {rpound_d, rpiast_d, rnick_d} = chg_coin;
        credit_d = credit_q - chg_val;
        if (credit_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Busy is registered from the next state so it lines up with state_q.
  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      credit_q <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      vend_q   <= 1'b0;
      rpound_q <= 1'b0;
      rpiast_q <= 1'b0;
      rnick_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      vend_q   <= vend_d;
      rpound_q <= rpound_d;
      rpiast_q <= rpiast_d;
      rnick_q  <= rnick_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.Accept     = accept_q;
  assign bus.Reject     = reject_q;
  assign bus.Vend       = vend_q;
  assign bus.RetPound   = rpound_q;
  assign bus.RetPiaster = rpiast_q;
  assign bus.RetNickel  = rnick_q;
  assign bus.Credit     = credit_q;
  assign bus.Busy       = busy_q;

endmodule
